pipelined_cla_adder: RTL and testbench

Parametrised, pipelined successor to the combinational carry lookahead adder. It adds or subtracts two WIDTH-bit operands using GROUP_W-bit lookahead groups, with the group chain split across NUM_STAGES register stages. It carries a valid/ready handshake on both sides so it can sit in a streaming datapath. It returns a WIDTH+1-bit result (carry-out as MSB) plus a signed overflow flag.

---
 rtl/pipelined_cla_adder.sv | 159 +++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead add/subtract with valid/ready on both sides.
// Group slices are spread over NUM_STAGES register stages, LSB slice first.
module pipelined_cla_adder #(
    parameter int WIDTH      = 16,
    parameter int GROUP_W    = 4,
    parameter int NUM_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add1,
    input  logic [WIDTH-1:0] i_add2,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_result,
    output logic             o_overflow
);
    localparam int NG    = WIDTH / GROUP_W;
    localparam int BASE  = NG / NUM_STAGES;
    localparam int EXTRA = NG % NUM_STAGES;
    localparam int LAST  = NUM_STAGES - 1;

    // Lower slices absorb the remainder groups, one each.
    function automatic int slice_n(input int k);
        return BASE + ((k < EXTRA) ? 1 : 0);
    endfunction

    function automatic int slice_lo(input int k);
        return k * BASE + ((k < EXTRA) ? k : EXTRA);
    endfunction

    logic en;

    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
        localparam int GN  = slice_n(gi);
        localparam int BLO = slice_lo(gi) * GROUP_W;
        localparam int SW  = GN * GROUP_W;
        localparam int BHI = BLO + SW;
        localparam int RW  = WIDTH - BLO;

        logic [RW-1:0]  a_in;
        logic [RW-1:0]  b_in;
        logic           c_in;
        logic           v_in;
        logic [SW-1:0]  bit_g;
        logic [SW-1:0]  bit_p;
        logic [SW-1:0]  bit_c;
        logic [GN-1:0]  grp_g;
        logic [GN-1:0]  grp_p;
        logic [GN:0]    grp_c;
        logic           prod;
        logic           acc;
        logic [SW-1:0]  new_sum;
        logic [BHI-1:0] s_d;
        logic [BHI-1:0] s_q;
        logic           c_d;
        logic           c_q;
        logic           v_q;

        if (gi == 0) begin : g_in
            assign a_in = i_add1;
            assign b_in = i_sub ? ~i_add2 : i_add2;
            assign c_in = i_sub | i_cin;
            assign v_in = i_valid;
            assign s_d  = new_sum;
        end else begin : g_in
            assign a_in = g_stage[gi-1].g_fwd.a_q;
            assign b_in = g_stage[gi-1].g_fwd.b_q;
            assign c_in = g_stage[gi-1].c_q;
            assign v_in = g_stage[gi-1].v_q;
            assign s_d  = {new_sum, g_stage[gi-1].s_q};
        end

        always_comb begin
            bit_g = a_in[SW-1:0] & b_in[SW-1:0];
            bit_p = a_in[SW-1:0] ^ b_in[SW-1:0];
            grp_g = '0;
            grp_p = '1;
            for (int j = 0; j < GN; j++) begin
                for (int i = 0; i < GROUP_W; i++) begin
                    grp_g[j] = bit_g[j*GROUP_W+i] | (bit_p[j*GROUP_W+i] & grp_g[j]);
                    grp_p[j] = grp_p[j] & bit_p[j*GROUP_W+i];
                end
            end
            // Each group carry is a flat sum of products over the slice.
            grp_c    = '0;
            grp_c[0] = c_in;
            prod     = 1'b0;
            acc      = 1'b0;
            for (int j = 0; j < GN; j++) begin
                prod = c_in;
                for (int m = 0; m <= j; m++) prod = prod & grp_p[m];
                acc = prod;
                for (int i = 0; i <= j; i++) begin
                    prod = grp_g[i];
                    for (int m = i + 1; m <= j; m++) prod = prod & grp_p[m];
                    acc = acc | prod;
                end
                grp_c[j+1] = acc;
            end
            bit_c = '0;
            for (int j = 0; j < GN; j++) begin
                bit_c[j*GROUP_W] = grp_c[j];
                for (int i = 1; i < GROUP_W; i++) begin
                    bit_c[j*GROUP_W+i] = bit_g[j*GROUP_W+i-1]
                                       | (bit_p[j*GROUP_W+i-1] & bit_c[j*GROUP_W+i-1]);
                end
            end
            new_sum = bit_p ^ bit_c;
        end

        assign c_d = grp_c[GN];

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                s_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (en) begin
                s_q <= s_d;
                c_q <= c_d;
                v_q <= v_in;
            end
        end

        if (gi < LAST) begin : g_fwd
            // Only operand bits belonging to later slices travel on.
            logic [RW-SW-1:0] a_q;
            logic [RW-SW-1:0] b_q;
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_in[RW-1:SW];
                    b_q <= b_in[RW-1:SW];
                end
            end
        end else begin : g_last
            logic ovf_d;
            logic ovf_q;
            assign ovf_d = (a_in[RW-1] == b_in[RW-1]) && (new_sum[SW-1] != a_in[RW-1]);
            always_ff @(posedge i_clk) begin
                if (i_rst)   ovf_q <= 1'b0;
                else if (en) ovf_q <= ovf_d;
            end
        end
    end

    assign en         = i_ready || !g_stage[LAST].v_q;
    assign o_ready    = en;
    assign o_valid    = g_stage[LAST].v_q;
    assign o_result   = {g_stage[LAST].c_q, g_stage[LAST].s_q};
    assign o_overflow = g_stage[LAST].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed checks on an 8-bit/2-stage adder plus an exhaustive sweep
// of a 4-bit/3-stage adder under random output back-pressure.
module tb_pipelined_cla_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       v8_i, rdy8_o, cin8, sub8, v8_o, rdy8_i, ovf8;
    logic [7:0] a8, b8;
    logic [8:0] res8;
    logic       v4_i, rdy4_o, cin4, sub4, v4_o, rdy4_i, ovf4;
    logic [3:0] a4, b4;
    logic [4:0] res4;

    int n_tests = 0;
    int n_fail  = 0;

    pipelined_cla_adder #(.WIDTH(8), .GROUP_W(4), .NUM_STAGES(2)) u8 (
        .i_clk(clk), .i_rst(rst), .i_valid(v8_i), .o_ready(rdy8_o),
        .i_add1(a8), .i_add2(b8), .i_cin(cin8), .i_sub(sub8),
        .o_valid(v8_o), .i_ready(rdy8_i), .o_result(res8), .o_overflow(ovf8)
    );

    pipelined_cla_adder #(.WIDTH(4), .GROUP_W(1), .NUM_STAGES(3)) u4 (
        .i_clk(clk), .i_rst(rst), .i_valid(v4_i), .o_ready(rdy4_o),
        .i_add1(a4), .i_add2(b4), .i_cin(cin4), .i_sub(sub4),
        .o_valid(v4_o), .i_ready(rdy4_i), .o_result(res4), .o_overflow(ovf4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated operation on the 8-bit adder: latency 2, single-cycle valid.
    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sub,
                        input logic [8:0] er, input logic eo);
        a8 = a; b8 = b; cin8 = cin; sub8 = sub; v8_i = 1'b1;
        step();
        v8_i = 1'b0;
        chk({tag, ".lat1"}, 32'(v8_o), 32'd0);
        step();
        chk({tag, ".valid"}, 32'(v8_o), 32'd1);
        chk({tag, ".result"}, 32'(res8), 32'(er));
        chk({tag, ".ovf"}, 32'(ovf8), 32'(eo));
        $display("[TB] %s: a=%0d b=%0d cin=%0d sub=%0d -> result=%h ovf=%0d",
                 tag, a, b, cin, sub, res8, ovf8);
        step();
        chk({tag, ".drop"}, 32'(v8_o), 32'd0);
    endtask

    function automatic logic [5:0] golden4(input int n);
        logic [3:0] a, b, bb;
        logic       c0, o;
        logic [4:0] r;
        a  = n[3:0];
        b  = n[7:4];
        bb = n[9] ? ~b : b;
        c0 = n[9] ? 1'b1 : n[8];
        r  = {1'b0, a} + {1'b0, bb} + {4'b0, c0};
        o  = (a[3] == bb[3]) && (r[3] != a[3]);
        return {o, r};
    endfunction

    initial begin
        int         idx, nout, cyc, id;
        logic       acc;
        logic [5:0] exp6;
        int         exp_q[$];

        rst = 1'b1;
        v8_i = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; rdy8_i = 1'b1;
        v4_i = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0; rdy4_i = 1'b1;
        step();
        step();
        chk("rst.valid8", 32'(v8_o), 32'd0);
        chk("rst.result8", 32'(res8), 32'd0);
        chk("rst.ovf8", 32'(ovf8), 32'd0);
        chk("rst.valid4", 32'(v4_o), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst.ready8", 32'(rdy8_o), 32'd1);
        $display("[TB] reset: valid=%0d result=%h ready=%0d", v8_o, res8, rdy8_o);

        run8("t1.add_200_100", 8'd200, 8'd100, 1'b0, 1'b0, 9'h12C, 1'b0);
        run8("t2.add_127_1", 8'd127, 8'd1, 1'b0, 1'b0, 9'h080, 1'b1);
        run8("t2.add_255_0_c1", 8'd255, 8'd0, 1'b1, 1'b0, 9'h100, 1'b0);
        run8("t3.sub_5_7", 8'd5, 8'd7, 1'b0, 1'b1, 9'h0FE, 1'b0);
        run8("t3.sub_128_1", 8'd128, 8'd1, 1'b0, 1'b1, 9'h17F, 1'b1);
        run8("t3.sub_7_7", 8'd7, 8'd7, 1'b0, 1'b1, 9'h100, 1'b0);

        // Back-to-back stream with a two-cycle output stall.
        a8 = 8'd1; b8 = 8'd1; cin8 = 1'b0; sub8 = 1'b0; v8_i = 1'b1;
        step();
        a8 = 8'd2; b8 = 8'd2;
        step();
        chk("t4.first_valid", 32'(v8_o), 32'd1);
        chk("t4.first_result", 32'(res8), 32'h002);
        rdy8_i = 1'b0; a8 = 8'd3; b8 = 8'd3;
        #1;
        chk("t4.ready_low", 32'(rdy8_o), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t4.stall_valid", 32'(v8_o), 32'd1);
            chk("t4.stall_result", 32'(res8), 32'h002);
            chk("t4.stall_ready", 32'(rdy8_o), 32'd0);
            $display("[TB] t4.stall cycle %0d: result=%h ready=%0d", i, res8, rdy8_o);
        end
        rdy8_i = 1'b1;
        step();
        v8_i = 1'b0;
        chk("t4.second_valid", 32'(v8_o), 32'd1);
        chk("t4.second_result", 32'(res8), 32'h004);
        step();
        chk("t4.third_valid", 32'(v8_o), 32'd1);
        chk("t4.third_result", 32'(res8), 32'h006);
        step();
        chk("t4.drain", 32'(v8_o), 32'd0);
        $display("[TB] t4.stream: results 2,4,6 drained");

        // Reset with one op in stage 0 and another being offered.
        a8 = 8'd10; b8 = 8'd20; v8_i = 1'b1;
        step();
        a8 = 8'd30; b8 = 8'd40; rst = 1'b1;
        step();
        rst = 1'b0; v8_i = 1'b0;
        chk("t5.valid", 32'(v8_o), 32'd0);
        chk("t5.result", 32'(res8), 32'd0);
        chk("t5.ovf", 32'(ovf8), 32'd0);
        #1;
        chk("t5.ready", 32'(rdy8_o), 32'd1);
        step();
        chk("t5.gone1", 32'(v8_o), 32'd0);
        step();
        chk("t5.gone2", 32'(v8_o), 32'd0);
        $display("[TB] t5.reset: in-flight ops discarded");
        run8("t5.after", 8'd9, 8'd8, 1'b0, 1'b0, 9'h011, 1'b0);

        // Exhaustive sweep of the 4-bit adder, continuous valid, random ready.
        idx = 0; nout = 0; cyc = 0;
        a4 = 4'd0; b4 = 4'd0; cin4 = 1'b0; sub4 = 1'b0; v4_i = 1'b1;
        while (nout < 1024 && cyc < 20000) begin
            rdy4_i = ($urandom_range(0, 3) != 0);
            #1;
            if (v4_o && rdy4_i) begin
                if (exp_q.size() == 0) begin
                    chk("t6.spurious", 32'(exp_q.size()), 32'd1);
                end else begin
                    id   = exp_q.pop_front();
                    exp6 = golden4(id);
                    chk("t6.result", 32'(res4), 32'(exp6[4:0]));
                    chk("t6.ovf", 32'(ovf4), 32'(exp6[5]));
                    $display("[TB] t6 op %0d: result=%h ovf=%0d", id, res4, ovf4);
                end
                nout++;
            end
            acc = v4_i && rdy4_o;
            step();
            if (acc) begin
                exp_q.push_back(idx);
                idx++;
                if (idx < 1024) begin
                    a4 = 4'(idx); b4 = 4'(idx >> 4); cin4 = idx[8]; sub4 = idx[9];
                end else begin
                    v4_i = 1'b0;
                end
            end
            cyc++;
        end
        chk("t6.count", 32'(nout), 32'd1024);
        chk("t6.leftover", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
